progmem_arbiter: RTL and testbench
==================================

# progmem_arbiter

Shares the single-port program memory (`progmem`, DW-bit words, 2^AW entries, synchronous read) between the CPU instruction-fetch port and the program loader port. After reset it runs a boot phase in which only the loader may access memory and the CPU is held stopped. Once the loader signals completion, it arbitrates fetch and loader requests round-robin, one memory access per cycle. It sits between the fetch stage and the loader on one side and `progmem` on the other.

## Interface
- AW, 4, memory address width (16 words)
- DW, 16, memory data width
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- f_req  in  1  fetch read request; held with f_addr until f_gnt
- f_addr  in  AW  fetch word address
- f_gnt  out  1  fetch request accepted this cycle
- f_rvalid  out  1  f_rdata valid (cycle after f_gnt)
- f_rdata  out  DW  fetch read data
- l_req  in  1  loader request; held with l_we/l_addr/l_din until l_gnt
- l_we  in  1  1 = write, 0 = read
- l_addr  in  AW  loader word address
- l_din  in  DW  loader write data
- l_done  in  1  single-cycle pulse: program load complete
- l_gnt  out  1  loader request accepted; for writes the write commits on this edge
- l_rvalid  out  1  l_rdata valid (cycle after a read l_gnt)
- l_rdata  out  DW  loader read data
- mem_addr  out  AW  to progmem addr
- mem_din  out  DW  to progmem din
- mem_we  out  1  to progmem write_en
- mem_dout  in  DW  from progmem dout, valid one cycle after address presented
- cpu_run  out  1  CPU enable; 0 in BOOT, 1 in RUN
- wr_count  out  AW+1  number of loader writes committed, saturating at 2^AW

## Operation
- States: BOOT (reset state) and RUN. BOOT→RUN on l_done=1 sampled at a rising edge. RUN persists until reset; l_done in RUN is ignored.
- BOOT:
  - f_gnt is forced to 0 and f_req is ignored.
  - l_gnt = l_req.
- RUN, arbitration:
  - Only one requester active: that requester is granted.
  - Both requesting: grant the requester that did not win the last contended cycle.
  - The `last` pointer updates only on contended cycles; it resets to "loader", so the first contention in RUN goes to fetch.
- Memory mux (combinational):
  - Loader granted: mem_addr=l_addr, mem_din=l_din, mem_we=l_we.
  - Fetch granted: mem_addr=f_addr, mem_we=0, mem_din=0.
  - No grant: mem_addr=0, mem_din=0, mem_we=0.
- Response tracking:
  - Registers f_rvalid <= f_gnt and l_rvalid <= l_gnt & ~l_we.
  - f_rdata = l_rdata = mem_dout, qualified by the respective rvalid.
- wr_count increments on each cycle with l_gnt & l_we, saturating at 2^AW (no wrap). Rewrites to the same address still count.
- Loader writes are permitted in RUN (self-modifying and patching use).

## Timing
- Grants are combinational from req and registered state. Zero-cycle accept when uncontended.
- Read latency is 1 cycle: gnt at edge N, rvalid high from N to N+1.
- A requester issuing back-to-back requests may be granted every cycle when uncontended. Under continuous contention each side gets every other cycle.
- BOOT→RUN: if l_done is sampled at edge N, cpu_run is 1 after edge N. An l_req in the same cycle as l_done is still served, under BOOT rules.
- Write then read of the same address in consecutive grants returns the new data (progmem write-first).
- Reset values while resetn=0:
  - state=BOOT, cpu_run=0, f_rvalid=0, l_rvalid=0, wr_count=0, last=loader.
  - f_gnt=l_gnt=mem_we=0 (grants are forced low while resetn=0).
- Reset asserted mid-access drops any pending rvalid immediately. No response is produced for an access granted in the cycle reset asserts.

## Test plan
- Boot load: after reset, loader writes 0x0006@3, 0x0008@4, 0x000A@5 in consecutive cycles → l_gnt each cycle, wr_count=3, cpu_run=0, f_req=1 meanwhile never granted.
- Boot exit: pulse l_done → cpu_run=1 next edge. Fetch of addr 4 → f_gnt same cycle, f_rvalid next cycle with f_rdata=0x0008.
- Contention: f_req and l_req (read addr 5) held together for 4 cycles in RUN → grants in order fetch, loader, fetch, loader. Loader rdata is 0x000A.
- Saturation: 18 loader writes → wr_count reaches 16 and holds.
- Write-then-read: in RUN, loader writes 0x1234@3, then fetch reads addr 3 the next cycle → f_rdata=0x1234.
- Reset mid-op: assert resetn=0 in the cycle after an f_gnt → f_rvalid=0, cpu_run=0, state BOOT. After release, a fetch request is not granted.

Source files
------------

// File: rtl/progmem_arbiter.sv
// rtl/progmem_arbiter.sv - program memory arbiter between CPU fetch and program loader
//
// Purpose: shares the single-port, synchronous-read progmem between the CPU
// instruction-fetch port and the program loader. After reset the block is in
// BOOT: only the loader is served and the CPU is held stopped. A loader l_done
// pulse moves it to RUN, where fetch and loader are arbitrated round-robin,
// one memory access per cycle.
//
// Ports:
//   clk_i, resetn_i          clock, asynchronous active-low reset
//   f_req_i/f_addr_i         fetch read request and word address
//   f_gnt_o                  fetch accepted this cycle
//   f_rvalid_o/f_rdata_o     fetch read response, one cycle after f_gnt_o
//   l_req_i/l_we_i/l_addr_i/l_din_i  loader request (read or write)
//   l_done_i                 loader completion pulse (BOOT -> RUN)
//   l_gnt_o                  loader accepted; writes commit on this edge
//   l_rvalid_o/l_rdata_o     loader read response, one cycle after a read grant
//   mem_addr_o/mem_din_o/mem_we_o/mem_dout_i  progmem port
//   cpu_run_o                CPU enable, high in RUN
//   wr_count_o               committed loader writes, saturating at 2^AW
module progmem_arbiter #(
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          resetn_i,
  input  logic          f_req_i,
  input  logic [AW-1:0] f_addr_i,
  output logic          f_gnt_o,
  output logic          f_rvalid_o,
  output logic [DW-1:0] f_rdata_o,
  input  logic          l_req_i,
  input  logic          l_we_i,
  input  logic [AW-1:0] l_addr_i,
  input  logic [DW-1:0] l_din_i,
  input  logic          l_done_i,
  output logic          l_gnt_o,
  output logic          l_rvalid_o,
  output logic [DW-1:0] l_rdata_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_din_o,
  output logic          mem_we_o,
  input  logic [DW-1:0] mem_dout_i,
  output logic          cpu_run_o,
  output logic [AW:0]   wr_count_o
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_e;

  // Winner of the last contended cycle.
  localparam logic LAST_FETCH  = 1'b0;
  localparam logic LAST_LOADER = 1'b1;

  localparam logic [AW:0] WR_MAX = {1'b1, {AW{1'b0}}};

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          f_rvalid_q, f_rvalid_d;
  logic          l_rvalid_q, l_rvalid_d;
  logic [AW:0]   wr_count_q, wr_count_d;
  logic          f_gnt, l_gnt;

  // Grants are combinational from requests and registered state. They are
  // gated by resetn_i so nothing is accepted while reset is held.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (resetn_i) begin
      if (state_q == BOOT) begin
        l_gnt = l_req_i;
      end else if (f_req_i && l_req_i) begin
        // Contended: the side that lost last time wins now.
        if (last_q == LAST_LOADER) f_gnt = 1'b1;
        else                       l_gnt = 1'b1;
      end else begin
        f_gnt = f_req_i;
        l_gnt = l_req_i;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    f_rvalid_d = f_gnt;
    l_rvalid_d = l_gnt & ~l_we_i;
    wr_count_d = wr_count_q;

    if (state_q == BOOT && l_done_i) state_d = RUN;

    // Pointer only moves when both sides actually competed.
    if (state_q == RUN && f_req_i && l_req_i && resetn_i)
      last_d = f_gnt ? LAST_FETCH : LAST_LOADER;

    if (l_gnt && l_we_i && wr_count_q != WR_MAX)
      wr_count_d = wr_count_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= BOOT;
      last_q     <= LAST_LOADER;
      f_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      f_rvalid_q <= f_rvalid_d;
      l_rvalid_q <= l_rvalid_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Memory port mux; an idle port drives zeros.
  always_comb begin
    mem_addr_o = '0;
    mem_din_o  = '0;
    mem_we_o   = 1'b0;
    if (l_gnt) begin
      mem_addr_o = l_addr_i;
      mem_din_o  = l_din_i;
      mem_we_o   = l_we_i;
    end else if (f_gnt) begin
      mem_addr_o = f_addr_i;
    end
  end

  assign f_gnt_o    = f_gnt;
  assign l_gnt_o    = l_gnt;
  assign f_rvalid_o = f_rvalid_q;
  assign l_rvalid_o = l_rvalid_q;
  assign f_rdata_o  = f_rvalid_q ? mem_dout_i : '0;
  assign l_rdata_o  = l_rvalid_q ? mem_dout_i : '0;
  assign cpu_run_o  = (state_q == RUN);
  assign wr_count_o = wr_count_q;

endmodule

// File: tb/tb_progmem_arbiter.sv
// tb/tb_progmem_arbiter.sv - directed self-checking bench for progmem_arbiter
module tb_progmem_arbiter;

  localparam int AW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt, f_rvalid;
  logic [DW-1:0] f_rdata;
  logic          l_req, l_we, l_done;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_din;
  logic          l_gnt, l_rvalid;
  logic [DW-1:0] l_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic          mem_we, cpu_run;
  logic [AW:0]   wr_count;

  logic [DW-1:0] mem [16];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  progmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk_i(clk), .resetn_i(resetn),
    .f_req_i(f_req), .f_addr_i(f_addr), .f_gnt_o(f_gnt),
    .f_rvalid_o(f_rvalid), .f_rdata_o(f_rdata),
    .l_req_i(l_req), .l_we_i(l_we), .l_addr_i(l_addr), .l_din_i(l_din),
    .l_done_i(l_done), .l_gnt_o(l_gnt), .l_rvalid_o(l_rvalid), .l_rdata_o(l_rdata),
    .mem_addr_o(mem_addr), .mem_din_o(mem_din), .mem_we_o(mem_we),
    .mem_dout_i(mem_dout), .cpu_run_o(cpu_run), .wr_count_o(wr_count)
  );

  // Write-first synchronous single-port progmem.
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_din;
      mem_dout      <= mem_din;
    end else begin
      mem_dout <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] boot_data [3];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem_dout = '0;
    boot_data[0] = 16'h0006;
    boot_data[1] = 16'h0008;
    boot_data[2] = 16'h000A;

    // Reset with every request raised: nothing may be granted.
    resetn = 1'b0; f_req = 1'b1; f_addr = 4'd4;
    l_req = 1'b1; l_we = 1'b1; l_addr = 4'd1; l_din = 16'hFFFF; l_done = 1'b0;
    #12;
    check("rst_f_gnt", f_gnt, 0);
    check("rst_l_gnt", l_gnt, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_cpu_run", cpu_run, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_rvalid", {f_rvalid, l_rvalid}, 0);

    // Boot load with fetch requesting throughout.
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      l_req = 1'b1; l_we = 1'b1; l_addr = AW'(3 + i); l_din = boot_data[i];
      #1;
      check("boot_l_gnt", l_gnt, 1);
      check("boot_f_gnt", f_gnt, 0);
      check("boot_mem", {mem_we, mem_addr, mem_din}, {1'b1, AW'(3 + i), boot_data[i]});
      @(negedge clk);
    end
    l_req = 1'b0;
    #1;
    check("boot_wr_count", wr_count, 3);
    check("boot_cpu_run", cpu_run, 0);
    check("boot_l_rvalid", l_rvalid, 0);
    check("boot_f_gnt_idle", f_gnt, 0);

    // Boot exit.
    l_done = 1'b1;
    #1;
    check("done_f_gnt", f_gnt, 0);
    next_cycle();
    check("run_cpu_run", cpu_run, 1);
    @(negedge clk);
    l_done = 1'b0; f_addr = 4'd4;
    #1;
    check("run_f_gnt", f_gnt, 1);
    check("run_mem", {mem_we, mem_addr}, {1'b0, 4'd4});
    next_cycle();
    check("run_f_rvalid", f_rvalid, 1);
    check("run_f_rdata", f_rdata, 16'h0008);

    // Contention: fetch addr 4 vs loader read addr 5.
    @(negedge clk);
    l_req = 1'b1; l_we = 1'b0; l_addr = 4'd5;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cont_f_gnt", f_gnt, (i % 2 == 0));
      check("cont_l_gnt", l_gnt, (i % 2 == 1));
      next_cycle();
      check("cont_f_rvalid", f_rvalid, (i % 2 == 0));
      check("cont_l_rvalid", l_rvalid, (i % 2 == 1));
      if (i % 2 == 0) check("cont_f_rdata", f_rdata, 16'h0008);
      else            check("cont_l_rdata", l_rdata, 16'h000A);
      @(negedge clk);
    end
    f_req = 1'b0; l_req = 1'b0;

    // Write then read of the same address.
    l_req = 1'b1; l_we = 1'b1; l_addr = 4'd3; l_din = 16'h1234;
    #1;
    check("wtr_l_gnt", l_gnt, 1);
    @(negedge clk);
    l_req = 1'b0; f_req = 1'b1; f_addr = 4'd3;
    #1;
    check("wtr_f_gnt", f_gnt, 1);
    check("wtr_wr_count", wr_count, 4);
    next_cycle();
    check("wtr_f_rdata", f_rdata, 16'h1234);
    @(negedge clk);
    f_req = 1'b0;

    // Saturation: 18 more writes from a count of 4.
    for (int i = 0; i < 18; i++) begin
      l_req = 1'b1; l_we = 1'b1; l_addr = AW'(i); l_din = DW'(i);
      next_cycle();
      check("sat_wr_count", wr_count, (4 + i + 1 > 16) ? 16 : 4 + i + 1);
      @(negedge clk);
    end
    l_req = 1'b0;

    // Reset in the cycle after a fetch grant.
    f_req = 1'b1; f_addr = 4'd3;
    #1;
    check("rmid_f_gnt", f_gnt, 1);
    next_cycle();
    check("rmid_f_rvalid_pre", f_rvalid, 1);
    resetn = 1'b0;
    #1;
    check("rmid_f_rvalid", f_rvalid, 0);
    check("rmid_cpu_run", cpu_run, 0);
    check("rmid_wr_count", wr_count, 0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("rmid_boot_f_gnt", f_gnt, 0);
    next_cycle();
    check("rmid_boot_f_rvalid", f_rvalid, 0);
    check("rmid_boot_cpu_run", cpu_run, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
